pipelined_control_unit: RTL and testbench

- Parametrised successor to the single-cycle RV32I control decode for the 5-stage pipelined core.
- Decodes in Decode (D) and carries control through registered D→E, E→M and M→W stages.
- Resolves all six RV32I branch conditions in Execute (E) from ALU flags; self-flushes E on a taken branch or jump.
- Adds U-type (lui) and an illegal-opcode flag.

---
 rtl/pipelined_control_unit.sv | 173 +++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// RV32I control decode in D with registered D->E, E->M and M->W control stages.
// Optional JALR_EN: decodes jalr and drives pctargetsrc_e; otherwise jalr is illegal.
module pipelined_control_unit #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op_d,
  input  logic [2:0]           funct3_d,
  input  logic                 funct7b5_d,
  input  logic                 flush_e,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [IMMSRC_W-1:0]  immsrc_d,
  output logic                 illegal_d,
  output logic                 alusrc_e,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic [1:0]           resultsrc_e,
  output logic                 pcsrc_e,
  output logic                 pctargetsrc_e,
  output logic                 memwrite_m,
  output logic                 regwrite_m,
  output logic                 regwrite_w,
  output logic [1:0]           resultsrc_w
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
`ifdef JALR_EN
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  logic       regwrite_d, alusrc_d, memwrite_d, branch_d, jump_d;
  logic [1:0] resultsrc_d, aluop_d;
  logic [2:0] immsel_d;
  logic [3:0] alucode_d;
`ifdef JALR_EN
  logic       pctargetsrc_d;
`endif

  logic       regwrite_e, memwrite_e, branch_e, jump_e, cond_e;
  logic [2:0] funct3_e;
  logic [1:0] resultsrc_m;

  // Main decode; unsupported encodings leave every control at zero.
  always_comb begin
    regwrite_d  = 1'b0;
    immsel_d    = 3'b000;
    alusrc_d    = 1'b0;
    memwrite_d  = 1'b0;
    resultsrc_d = 2'b00;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    aluop_d     = 2'b00;
    illegal_d   = 1'b0;
`ifdef JALR_EN
    pctargetsrc_d = 1'b0;
`endif
    case (op_d)
      OP_LOAD:  begin regwrite_d = 1'b1; alusrc_d = 1'b1; resultsrc_d = 2'b01; end
      OP_STORE: begin immsel_d = 3'b001; alusrc_d = 1'b1; memwrite_d = 1'b1; end
      OP_RTYPE: begin regwrite_d = 1'b1; aluop_d = 2'b10; end
      OP_IALU:  begin regwrite_d = 1'b1; alusrc_d = 1'b1; aluop_d = 2'b10; end
      OP_BRANCH: begin
        if (funct3_d[2:1] == 2'b01) illegal_d = 1'b1;
        else begin immsel_d = 3'b010; branch_d = 1'b1; aluop_d = 2'b01; end
      end
      OP_JAL:   begin regwrite_d = 1'b1; immsel_d = 3'b011; resultsrc_d = 2'b10; jump_d = 1'b1; end
      OP_LUI:   begin regwrite_d = 1'b1; immsel_d = 3'b100; resultsrc_d = 2'b11; end
`ifdef JALR_EN
      OP_JALR: begin
        regwrite_d = 1'b1; alusrc_d = 1'b1; resultsrc_d = 2'b10;
        jump_d = 1'b1; pctargetsrc_d = 1'b1;
      end
`endif
      default:  illegal_d = 1'b1;
    endcase
  end

  // ALU decode; SUB for R-type only, since addi has no funct7 field.
  always_comb begin
    alucode_d = 4'b0000;
    case (aluop_d)
      2'b01: alucode_d = 4'b0001;
      2'b10: begin
        case (funct3_d)
          3'b000:  alucode_d = (op_d[5] & funct7b5_d) ? 4'b0001 : 4'b0000;
          3'b001:  alucode_d = 4'b0111;
          3'b010:  alucode_d = 4'b0101;
          3'b011:  alucode_d = 4'b0110;
          3'b100:  alucode_d = 4'b0100;
          3'b101:  alucode_d = funct7b5_d ? 4'b1001 : 4'b1000;
          3'b110:  alucode_d = 4'b0011;
          default: alucode_d = 4'b0010;
        endcase
      end
      default: alucode_d = 4'b0000;
    endcase
  end

  assign immsrc_d = IMMSRC_W'(immsel_d);

  // A taken branch/jump in E turns the instruction behind it into a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush_e || pcsrc_e) begin
      regwrite_e   <= 1'b0;
      resultsrc_e  <= 2'b00;
      memwrite_e   <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      alusrc_e     <= 1'b0;
      alucontrol_e <= '0;
      funct3_e     <= 3'b000;
    end else begin
      regwrite_e   <= regwrite_d;
      resultsrc_e  <= resultsrc_d;
      memwrite_e   <= memwrite_d;
      branch_e     <= branch_d;
      jump_e       <= jump_d;
      alusrc_e     <= alusrc_d;
      alucontrol_e <= ALUCTRL_W'(alucode_d);
      funct3_e     <= funct3_d;
    end
  end

`ifdef JALR_EN
  always_ff @(posedge clk) begin
    if (reset || flush_e || pcsrc_e) pctargetsrc_e <= 1'b0;
    else                             pctargetsrc_e <= pctargetsrc_d;
  end
`else
  assign pctargetsrc_e = 1'b0;
`endif

  always_comb begin
    cond_e = 1'b0;
    case (funct3_e)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = ~zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = ~lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = ~ltu_e;
      default: cond_e = 1'b0;
    endcase
  end

  assign pcsrc_e = (branch_e & cond_e) | jump_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m  <= 1'b0;
      memwrite_m  <= 1'b0;
      resultsrc_m <= 2'b00;
      regwrite_w  <= 1'b0;
      resultsrc_w <= 2'b00;
    end else begin
      regwrite_m  <= regwrite_e;
      memwrite_m  <= memwrite_e;
      resultsrc_m <= resultsrc_e;
      regwrite_w  <= regwrite_m;
      resultsrc_w <= resultsrc_m;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: reference decode model feeding a stage scoreboard.
// Honours JALR_EN the same way as the design.
module tb_pipelined_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       pctargetsrc;
    logic       alusrc;
    logic [3:0] alucontrol;
    logic [2:0] funct3;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op_d = OP_NOP;
  logic [2:0] funct3_d = 3'b000;
  logic funct7b5_d = 1'b0, flush_e = 1'b0, zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;
  logic [2:0] immsrc_d;
  logic illegal_d, alusrc_e, pcsrc_e, pctargetsrc_e, memwrite_m, regwrite_m, regwrite_w;
  logic [3:0] alucontrol_e;
  logic [1:0] resultsrc_e, resultsrc_w;

  ctl_t q[$];
  ctl_t exp_e = '0, exp_m = '0, exp_w = '0;
  logic exp_illegal = 1'b0, exp_pcsrc = 1'b0;
  logic [2:0] exp_imm = 3'b000;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_control_unit #(.ALUCTRL_W(4), .IMMSRC_W(3)) dut (
    .clk(clk), .reset(reset), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
    .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .immsrc_d(immsrc_d), .illegal_d(illegal_d), .alusrc_e(alusrc_e),
    .alucontrol_e(alucontrol_e), .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e),
    .pctargetsrc_e(pctargetsrc_e), .memwrite_m(memwrite_m), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w)
  );

  function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == OP_BR) return 4'd1;
    if (op != OP_R && op != OP_I) return 4'd0;
    case (f3)
      3'd0: return (op == OP_R && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      output logic ill, output logic [2:0] imm);
    ctl_t c;
    c = '0;
    ill = 1'b0;
    imm = 3'b000;
    case (op)
      OP_LW:  begin c.regwrite = 1; c.alusrc = 1; c.resultsrc = 2'b01; end
      OP_SW:  begin imm = 3'b001; c.alusrc = 1; c.memwrite = 1; end
      OP_R:   c.regwrite = 1;
      OP_I:   begin c.regwrite = 1; c.alusrc = 1; end
      OP_BR:  if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
              else begin imm = 3'b010; c.branch = 1; end
      OP_JAL: begin c.regwrite = 1; imm = 3'b011; c.resultsrc = 2'b10; c.jump = 1; end
      OP_LUI: begin c.regwrite = 1; imm = 3'b100; c.resultsrc = 2'b11; end
`ifdef JALR_EN
      OP_JR:  begin c.regwrite = 1; c.alusrc = 1; c.resultsrc = 2'b10; c.jump = 1; c.pctargetsrc = 1; end
`endif
      default: ill = 1'b1;
    endcase
    if (!ill) c.alucontrol = ref_alu(op, f3, f7);
    c.funct3 = f3;
    return c;
  endfunction

  function automatic logic ref_pcsrc(input ctl_t e, input logic z, input logic l, input logic lu);
    logic cond;
    case (e.funct3)
      3'b000: cond = z;
      3'b001: cond = !z;
      3'b100: cond = l;
      3'b101: cond = !l;
      3'b110: cond = lu;
      3'b111: cond = !lu;
      default: cond = 1'b0;
    endcase
    return (e.branch && cond) || e.jump;
  endfunction

  task automatic set_inputs(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic fl,
                            input logic z, input logic l, input logic lu, input logic rst);
    ctl_t ecur, unused;
    @(negedge clk);
    op_d = op; funct3_d = f3; funct7b5_d = f7; flush_e = fl;
    zero_e = z; lt_e = l; ltu_e = lu; reset = rst;
    unused = ref_decode(op, f3, f7, exp_illegal, exp_imm);
    ecur = (q.size() >= 2) ? q[1] : '0;
    exp_pcsrc = ref_pcsrc(ecur, z, l, lu);
    #1;
  endtask

  // Pushes the record entering E, pops the one leaving for W.
  task automatic clock_edge();
    ctl_t ne;
    logic ill;
    logic [2:0] imm;
    if (reset) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      exp_w = '0;
    end else begin
      ne = ref_decode(op_d, funct3_d, funct7b5_d, ill, imm);
      if (flush_e || exp_pcsrc) ne = '0;
      q.push_back(ne);
      exp_w = q.pop_front();
    end
    @(posedge clk);
    #1;
    exp_m = q[0];
    exp_e = q[1];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      clock_edge();
      checks++; if ({regwrite_w, resultsrc_w, regwrite_m, memwrite_m} !== 5'b0) begin fails++; $display("[TB] FAIL reset_mw: got %b want 00000", {regwrite_w, resultsrc_w, regwrite_m, memwrite_m}); end
      checks++; if ({alusrc_e, alucontrol_e, resultsrc_e, pcsrc_e, pctargetsrc_e} !== 9'b0) begin fails++; $display("[TB] FAIL reset_e: got %b want 000000000", {alusrc_e, alucontrol_e, resultsrc_e, pcsrc_e, pctargetsrc_e}); end
    end
    set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (resultsrc_e !== 2'b01 || alusrc_e !== 1'b1) begin fails++; $display("[TB] FAIL lw_e: got rs=%b as=%b want rs=01 as=1", resultsrc_e, alusrc_e); end
    for (int i = 0; i < 2; i++) begin
      set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clock_edge();
    end
    checks++; if (regwrite_w !== 1'b1 || resultsrc_w !== 2'b01) begin fails++; $display("[TB] FAIL lw_w: got rw=%b rs=%b want rw=1 rs=01", regwrite_w, resultsrc_w); end
    checks++; if (regwrite_w !== exp_w.regwrite || resultsrc_w !== exp_w.resultsrc) begin fails++; $display("[TB] FAIL lw_w_sb: got rw=%b rs=%b want rw=%b rs=%b", regwrite_w, resultsrc_w, exp_w.regwrite, exp_w.resultsrc); end
    // Reset with sw and lw in flight drops both.
    set_inputs(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clock_edge();
    checks++; if ({memwrite_m, regwrite_m, regwrite_w, resultsrc_e} !== 5'b0) begin fails++; $display("[TB] FAIL midreset: got %b want 00000", {memwrite_m, regwrite_m, regwrite_w, resultsrc_e}); end
  endtask

  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic f7; logic [3:0] code; } alu_vec_t;

  task automatic test_alu_decode();
    alu_vec_t v [12] = '{
      '{OP_R, 3'd0, 1'b1, 4'b0001}, '{OP_R, 3'd5, 1'b1, 4'b1001}, '{OP_R, 3'd0, 1'b0, 4'b0000},
      '{OP_I, 3'd0, 1'b1, 4'b0000}, '{OP_I, 3'd5, 1'b1, 4'b1001}, '{OP_R, 3'd2, 1'b0, 4'b0101},
      '{OP_R, 3'd3, 1'b0, 4'b0110}, '{OP_R, 3'd4, 1'b0, 4'b0100}, '{OP_I, 3'd6, 1'b0, 4'b0011},
      '{OP_R, 3'd7, 1'b0, 4'b0010}, '{OP_R, 3'd1, 1'b0, 4'b0111}, '{OP_I, 3'd5, 1'b0, 4'b1000}};
    for (int i = 0; i < 12; i++) begin
      set_inputs(v[i].op, v[i].f3, v[i].f7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clock_edge();
      checks++; if (alucontrol_e !== v[i].code) begin fails++; $display("[TB] FAIL alu_%0d: got %b want %b", i, alucontrol_e, v[i].code); end
      checks++; if (alusrc_e !== exp_e.alusrc) begin fails++; $display("[TB] FAIL alusrc_%0d: got %b want %b", i, alusrc_e, exp_e.alusrc); end
    end
  endtask

  typedef struct packed { logic [2:0] f3; logic z; logic l; logic lu; logic taken; } br_vec_t;

  task automatic test_branch();
    br_vec_t v [8] = '{
      '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
      '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1}, '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1}, '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0}, '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      set_inputs(OP_BR, v[i].f3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clock_edge();
      set_inputs(OP_I, 3'd0, 1'b0, 1'b0, v[i].z, v[i].l, v[i].lu, 1'b0);
      checks++; if (pcsrc_e !== v[i].taken) begin fails++; $display("[TB] FAIL br_pcsrc_%0d: got %b want %b", i, pcsrc_e, v[i].taken); end
      clock_edge();
      checks++; if (alusrc_e !== !v[i].taken) begin fails++; $display("[TB] FAIL br_next_%0d: got alusrc=%b want %b", i, alusrc_e, !v[i].taken); end
    end
    // A taken bge leaves the older lw in M/W untouched.
    set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_BR, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pcsrc_e !== 1'b1) begin fails++; $display("[TB] FAIL bge_taken: got %b want 1", pcsrc_e); end
    clock_edge();
    checks++; if (regwrite_w !== 1'b1 || resultsrc_w !== 2'b01 || alusrc_e !== 1'b0) begin fails++; $display("[TB] FAIL bge_mw: got rw=%b rs=%b as=%b want 1 01 0", regwrite_w, resultsrc_w, alusrc_e); end
    set_inputs(OP_BR, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (illegal_d !== 1'b1 || immsrc_d !== 3'b000) begin fails++; $display("[TB] FAIL br_f3_010: got ill=%b imm=%b want 1 000", illegal_d, immsrc_d); end
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (pcsrc_e !== 1'b0) begin fails++; $display("[TB] FAIL br_f3_010_pcsrc: got %b want 0", pcsrc_e); end
    clock_edge();
  endtask

  task automatic test_flush();
    set_inputs(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_SW, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (resultsrc_e !== 2'b01) begin fails++; $display("[TB] FAIL flush_lw_e: got %b want 01", resultsrc_e); end
    clock_edge();
    checks++; if (regwrite_m !== 1'b1 || alusrc_e !== 1'b0) begin fails++; $display("[TB] FAIL flush_bubble: got rwm=%b as=%b want 1 0", regwrite_m, alusrc_e); end
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (memwrite_m !== 1'b0 || regwrite_w !== 1'b1) begin fails++; $display("[TB] FAIL flush_m: got mw=%b rww=%b want 0 1", memwrite_m, regwrite_w); end
    set_inputs(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (memwrite_m !== 1'b1) begin fails++; $display("[TB] FAIL sw_m: got %b want 1", memwrite_m); end
    // flush_e together with a taken jal still costs exactly one bubble.
    set_inputs(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    set_inputs(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pcsrc_e !== 1'b1 || pctargetsrc_e !== 1'b0) begin fails++; $display("[TB] FAIL jal_e: got pcsrc=%b pts=%b want 1 0", pcsrc_e, pctargetsrc_e); end
    clock_edge();
    checks++; if (alusrc_e !== 1'b0) begin fails++; $display("[TB] FAIL both_bubble: got %b want 0", alusrc_e); end
    set_inputs(OP_I, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (alusrc_e !== 1'b1 || resultsrc_w !== 2'b10) begin fails++; $display("[TB] FAIL both_after: got as=%b rsw=%b want 1 10", alusrc_e, resultsrc_w); end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      clock_edge();
    end
    for (int i = 0; i < 5; i++) begin
      set_inputs(OP_SYS, 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (illegal_d !== 1'b1 || immsrc_d !== 3'b000) begin fails++; $display("[TB] FAIL sys_d_%0d: got ill=%b imm=%b want 1 000", i, illegal_d, immsrc_d); end
      clock_edge();
      checks++; if ({memwrite_m, regwrite_w, alucontrol_e, resultsrc_e, alusrc_e} !== 9'b0) begin fails++; $display("[TB] FAIL sys_pipe_%0d: got %b want 000000000", i, {memwrite_m, regwrite_w, alucontrol_e, resultsrc_e, alusrc_e}); end
    end
  endtask

  task automatic test_jalr();
    set_inputs(OP_JR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef JALR_EN
    checks++; if (illegal_d !== 1'b0) begin fails++; $display("[TB] FAIL jalr_d: got %b want 0", illegal_d); end
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pcsrc_e !== 1'b1 || pctargetsrc_e !== 1'b1) begin fails++; $display("[TB] FAIL jalr_e: got pcsrc=%b pts=%b want 1 1", pcsrc_e, pctargetsrc_e); end
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (resultsrc_w !== 2'b10 || regwrite_w !== 1'b1) begin fails++; $display("[TB] FAIL jalr_w: got rs=%b rw=%b want 10 1", resultsrc_w, regwrite_w); end
`else
    checks++; if (illegal_d !== 1'b1) begin fails++; $display("[TB] FAIL jalr_d: got %b want 1", illegal_d); end
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (pcsrc_e !== 1'b0 || pctargetsrc_e !== 1'b0) begin fails++; $display("[TB] FAIL jalr_e: got pcsrc=%b pts=%b want 0 0", pcsrc_e, pctargetsrc_e); end
    clock_edge();
    set_inputs(OP_NOP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    checks++; if (regwrite_w !== 1'b0) begin fails++; $display("[TB] FAIL jalr_w: got %b want 0", regwrite_w); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_JR, OP_SYS, OP_NOP};
    for (int i = 0; i < 300; i++) begin
      set_inputs(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      checks++; if (illegal_d !== exp_illegal || immsrc_d !== exp_imm || pcsrc_e !== exp_pcsrc) begin fails++; $display("[TB] FAIL rnd_d_%0d: got ill=%b imm=%b pcsrc=%b want %b %b %b", i, illegal_d, immsrc_d, pcsrc_e, exp_illegal, exp_imm, exp_pcsrc); end
      clock_edge();
      checks++; if (alusrc_e !== exp_e.alusrc || alucontrol_e !== exp_e.alucontrol || resultsrc_e !== exp_e.resultsrc || pctargetsrc_e !== exp_e.pctargetsrc) begin fails++; $display("[TB] FAIL rnd_e_%0d: got as=%b ac=%b rs=%b pts=%b want %b %b %b %b", i, alusrc_e, alucontrol_e, resultsrc_e, pctargetsrc_e, exp_e.alusrc, exp_e.alucontrol, exp_e.resultsrc, exp_e.pctargetsrc); end
      checks++; if (memwrite_m !== exp_m.memwrite || regwrite_m !== exp_m.regwrite || regwrite_w !== exp_w.regwrite || resultsrc_w !== exp_w.resultsrc) begin fails++; $display("[TB] FAIL rnd_mw_%0d: got mw=%b rwm=%b rww=%b rsw=%b want %b %b %b %b", i, memwrite_m, regwrite_m, regwrite_w, resultsrc_w, exp_m.memwrite, exp_m.regwrite, exp_w.regwrite, exp_w.resultsrc); end
    end
  endtask

  initial begin
    $display("[TB] starting pipelined_control_unit bench");
    test_reset();
    test_alu_decode();
    test_branch();
    test_flush();
    test_illegal();
    test_jalr();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
